// File: rtl/pe_mac_dbuf.sv
// Systolic-array processing element with a double-buffered stationary operand.
// The shadow register fills through the neighbour shift chain while the active
// register feeds the MAC. Weights stream horizontally and partial sums flow
// vertically. The block supports signed or unsigned arithmetic, optional
// saturation, a sticky overflow flag and a per-PE bypass.
module pe_mac_dbuf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PSUM_W = 20,
  parameter bit          SIGNED = 1'b1,
  parameter bit          SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [DATA_W-1:0] stat_i,
  output logic [DATA_W-1:0] stat_o,
  input  logic              swap,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] weight_i,
  input  logic [PSUM_W-1:0] psum_i,
  input  logic              bypass,
  input  logic              clr_ovf,
  output logic              valid_o,
  output logic [DATA_W-1:0] weight_o,
  output logic [PSUM_W-1:0] psum_o,
  output logic              ovf_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = PSUM_W + 1;

  if (PSUM_W < 2 * DATA_W) begin : g_bad_psum_w
    $error("pe_mac_dbuf: PSUM_W must be >= 2*DATA_W");
  end

  logic [DATA_W-1:0] shadow_q, active_q, weight_q;
  logic [PSUM_W-1:0] psum_q, psum_d;
  logic              valid_q, ovf_q, ovf_d;

  logic [PROD_W-1:0] op_a, op_w, prod;
  logic [SUM_W-1:0]  prod_ext, psum_ext, sum;
  logic              over_hi, over_lo;
  logic [PSUM_W-1:0] bound_hi, bound_lo, mac_res;

  // Multiply-accumulate datapath. Operands are extended to the full product
  // width, so the low PROD_W bits of the product are correct in either mode.
  // The extra sum bit always holds the exact result, because the product
  // magnitude is at most 2^(PSUM_W-2) (signed) or below 2^PSUM_W (unsigned).
  always_comb begin
    if (SIGNED) begin
      op_a     = {{DATA_W{active_q[DATA_W-1]}}, active_q};
      op_w     = {{DATA_W{weight_i[DATA_W-1]}}, weight_i};
    end else begin
      op_a     = {{DATA_W{1'b0}}, active_q};
      op_w     = {{DATA_W{1'b0}}, weight_i};
    end
    prod = op_a * op_w;
    if (SIGNED) begin
      prod_ext = {{(SUM_W - PROD_W){prod[PROD_W-1]}}, prod};
      psum_ext = {psum_i[PSUM_W-1], psum_i};
    end else begin
      prod_ext = {{(SUM_W - PROD_W){1'b0}}, prod};
      psum_ext = {1'b0, psum_i};
    end
    sum = psum_ext + prod_ext;
  end

  // Range detection and clamping of the extended sum.
  always_comb begin
    if (SIGNED) begin
      // The top two bits disagree only when the result leaves the PSUM_W range.
      over_hi  = ~sum[SUM_W-1] & sum[SUM_W-2];
      over_lo  = sum[SUM_W-1] & ~sum[SUM_W-2];
      bound_hi = {1'b0, {(PSUM_W - 1){1'b1}}};
      bound_lo = {1'b1, {(PSUM_W - 1){1'b0}}};
    end else begin
      over_hi  = sum[SUM_W-1];
      over_lo  = 1'b0;
      bound_hi = {PSUM_W{1'b1}};
      bound_lo = {PSUM_W{1'b0}};
    end
    if (SAT && over_hi) begin
      mac_res = bound_hi;
    end else if (SAT && over_lo) begin
      mac_res = bound_lo;
    end else begin
      mac_res = sum[PSUM_W-1:0];
    end
  end

  // Next-state values for the result register and the sticky flag.
  always_comb begin
    psum_d = psum_q;
    ovf_d  = ovf_q;
    if (valid_i) begin
      psum_d = bypass ? psum_i : mac_res;
    end
    // Setting the flag takes priority over a same-cycle clear.
    if (valid_i && !bypass && (over_hi || over_lo)) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Double buffer: swap reads the pre-edge shadow, so a same-cycle load is safe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (load_en) begin
        shadow_q <= stat_i;
      end
      if (swap) begin
        active_q <= shadow_q;
      end
    end
  end

  // Pipeline registers for the valid flag, weight, partial sum and overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      weight_q <= '0;
      psum_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        weight_q <= weight_i;
      end
      psum_q <= psum_d;
      ovf_q  <= ovf_d;
    end
  end

  assign stat_o   = shadow_q;
  assign valid_o  = valid_q;
  assign weight_o = weight_q;
  assign psum_o   = psum_q;
  assign ovf_o    = ovf_q;

endmodule

// File: doc/pe_mac_dbuf.md
Name: pe_mac_dbuf

Overview:
Parametrised systolic-array processing element that extends the team's 8-bit fully-connected PE.
- Stationary operand (ifmap) is double-buffered: a shadow register is loaded through a neighbour shift chain while the active register feeds the MAC.
- Weight streams horizontally with a valid qualifier; partial sum flows vertically.
- Adds configurable widths, signed/unsigned arithmetic, optional saturation, sticky overflow and a per-PE bypass mode.

Parameters:
DATA_W, 8, width of weight and stationary operand
PSUM_W, 20, width of partial sum in/out (must be >= 2*DATA_W; elaboration error otherwise)
SIGNED, 1, 1 = two's-complement operands and psum; 0 = unsigned
SAT, 1, 1 = clamp on overflow; 0 = wrap modulo 2^PSUM_W

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
load_en  in  1  shift stat_i into shadow register this cycle
stat_i  in  DATA_W  stationary operand from upstream neighbour / loader
stat_o  out  DATA_W  shadow register contents, to downstream neighbour's stat_i
swap  in  1  copy shadow into active register
valid_i  in  1  weight_i/psum_i valid this cycle
weight_i  in  DATA_W  streaming weight
psum_i  in  PSUM_W  incoming partial sum
bypass  in  1  pass psum_i unchanged (PE disabled)
clr_ovf  in  1  clear sticky overflow flag
valid_o  out  1  registered valid_i
weight_o  out  DATA_W  registered weight, to right neighbour
psum_o  out  PSUM_W  registered result
ovf_o  out  1  sticky overflow flag

Behaviour:
- Reset (rst_n=0 at posedge): shadow, active, weight_o, psum_o = 0; valid_o = 0; ovf_o = 0. Applies mid-operation; in-flight result is discarded. All other inputs are ignored during reset.
- Shadow: load_en=1 -> shadow <= stat_i; else hold. stat_o = shadow, so N chained PEs fill in N cycles (first value ends in the last PE).
- Active: swap=1 -> active <= shadow (pre-edge value); else hold. With swap and load_en in the same cycle, active gets the OLD shadow and shadow gets stat_i.
- MAC, latency 1 cycle: on valid_i=1 and bypass=0, psum_o <= sat(psum_i + active*weight_i).
  - The product uses the active value before any same-cycle swap.
  - Product is 2*DATA_W bits, sign- or zero-extended per SIGNED.
  - Sum is computed in PSUM_W+1 bits.
- Overflow:
  - Range is [-2^(PSUM_W-1), 2^(PSUM_W-1)-1] when SIGNED=1, [0, 2^PSUM_W-1] when SIGNED=0.
  - SAT=1: a result outside the range clamps to the nearest bound. SAT=0: low PSUM_W bits are kept.
  - Either way, ovf_o <= 1 on out-of-range.
- Bypass: valid_i=1 and bypass=1 -> psum_o <= psum_i; no overflow check.
- valid_o <= valid_i every cycle. weight_o <= weight_i when valid_i=1, else hold.
- valid_i=0 -> psum_o holds, valid_o=0.
- ovf_o: set by overflow, cleared by clr_ovf. When both occur in the same cycle, set wins (ovf_o=1).

Test Plan:
- Basic MAC (SIGNED=1, SAT=1, PSUM_W=20): load 5, swap, weight=-3, psum_i=100, valid_i=1 -> next cycle psum_o=85, valid_o=1, weight_o=-3, ovf_o=0.
- Saturation:
  - Positive: active=127, weight=127, psum_i=520000 -> psum_o=524287, ovf_o=1.
  - Negative: active=-128, weight=127, psum_i=-520000 -> psum_o=-524288.
  - Wrap (SAT=0): same positive case -> psum_o=-512447, ovf_o=1.
  - Clear: clr_ovf pulse with no overflow -> ovf_o=0.
- Chain load: 4 chained PEs, load_en for 4 cycles with stat_i=1,2,3,4 -> shadows PE0..PE3 = 4,3,2,1. Actives remain 0 until swap; after a swap pulse, actives = 4,3,2,1.
- Swap + load same cycle: shadow=7, active=2. Assert swap, load_en=1 (stat_i=9) and valid_i=1 (weight=10, psum_i=0) together -> psum_o=20, active=7, shadow=9. Next valid MAC with weight=1 -> psum_o=7.
- Bypass/hold: bypass=1, psum_i=1234 -> psum_o=1234. Then valid_i=0 for 3 cycles -> psum_o stays 1234, valid_o=0.
- Unsigned and reset: SIGNED=0, active=255, weight=255, psum_i=0 -> psum_o=65025. Assert rst_n=0 during a valid stream -> next cycle all outputs 0, and shadow/active read 0 after release.
